exec_seq: RTL and testbench

EXEC_SEQ -- requirements
Module: exec_seq

---
 rtl/exec_seq.sv | 110 +++++++++++
 tb/tb_exec_seq.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_seq.sv
// exec_seq: multi-cycle accumulator sequencer with an external ALU.
// Each instruction is FETCH -> EXEC -> WB; FETCH stalls until imem_valid.
module exec_seq #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 5,
    parameter int CNTR_WIDTH  = 8,
    parameter int REG_BIT_CNT = 3
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    output logic                             imem_req,
    output logic [CNTR_WIDTH-1:0]            imem_addr,
    input  logic                             imem_valid,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] imem_data,
    output logic [ADDR_WIDTH-1:0]            alu_op,
    output logic [DATA_WIDTH-1:0]            alu_in1,
    output logic [DATA_WIDTH-1:0]            alu_in2,
    input  logic [DATA_WIDTH-1:0]            alu_result,
    input  logic                             alu_zero,
    input  logic                             alu_neg,
    input  logic                             alu_pos,
    output logic [DATA_WIDTH-1:0]            acc,
    output logic [2:0]                       flags,
    output logic                             halted
);
    localparam int NREG = 1 << REG_BIT_CNT;

    // Opcodes 0..16 are ALU-class; 23 and above are unrecognised.
    localparam logic [ADDR_WIDTH-1:0] OP_NOP  = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] OP_LDI  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] OP_ADDI = ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] OP_SUBI = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] OP_NOT  = ADDR_WIDTH'(16);
    localparam logic [ADDR_WIDTH-1:0] OP_STR  = ADDR_WIDTH'(17);
    localparam logic [ADDR_WIDTH-1:0] OP_JMP  = ADDR_WIDTH'(18);
    localparam logic [ADDR_WIDTH-1:0] OP_JZ   = ADDR_WIDTH'(19);
    localparam logic [ADDR_WIDTH-1:0] OP_JLZ  = ADDR_WIDTH'(20);
    localparam logic [ADDR_WIDTH-1:0] OP_JGZ  = ADDR_WIDTH'(21);
    localparam logic [ADDR_WIDTH-1:0] OP_HLT  = ADDR_WIDTH'(22);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_WB, S_HALT} state_t;

    state_t                              r_state, w_next;
    logic [CNTR_WIDTH-1:0]               r_pc;
    logic [DATA_WIDTH-1:0]               r_acc;
    logic [2:0]                          r_flags;
    logic [ADDR_WIDTH+DATA_WIDTH-1:0]    r_ir;
    logic [DATA_WIDTH-1:0]               r_rf [NREG];

    logic [ADDR_WIDTH-1:0]  w_op;
    logic [DATA_WIDTH-1:0]  w_opnd;
    logic [REG_BIT_CNT-1:0] w_idx;
    logic                   w_is_alu, w_is_imm, w_take;

    assign w_op     = r_ir[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
    assign w_opnd   = r_ir[DATA_WIDTH-1:0];
    assign w_idx    = w_opnd[REG_BIT_CNT-1:0];
    assign w_is_alu = w_op <= OP_NOT;
    assign w_is_imm = w_op == OP_LDI || w_op == OP_ADDI || w_op == OP_SUBI;
    assign w_take   = w_op == OP_JMP || (w_op == OP_JZ && r_flags[0]) ||
                      (w_op == OP_JLZ && r_flags[1]) || (w_op == OP_JGZ && r_flags[2]);

    assign imem_req  = r_state == S_FETCH;
    assign imem_addr = r_pc;
    assign alu_op    = w_is_alu ? w_op : OP_NOP;
    assign alu_in1   = r_acc;
    assign alu_in2   = w_is_imm ? w_opnd : r_rf[w_idx];
    assign acc       = r_acc;
    assign flags     = r_flags;
    assign halted    = r_state == S_HALT;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = start ? S_FETCH : S_IDLE;
            S_FETCH: w_next = imem_valid ? S_EXEC : S_FETCH;
            S_EXEC:  w_next = S_WB;
            S_WB:    w_next = (w_op == OP_HLT) ? S_HALT : S_FETCH;
            S_HALT:  w_next = start ? S_FETCH : S_HALT;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= '0;
            r_acc   <= '0;
            r_flags <= '0;
            r_ir    <= {OP_NOP, {DATA_WIDTH{1'b0}}};
            for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
        end else begin
            if (r_state == S_FETCH && imem_valid) r_ir <= imem_data;
            if (r_state == S_HALT && start) r_pc <= '0;
            if (r_state == S_WB) begin
                if (w_is_alu) begin
                    r_acc   <= alu_result;
                    r_flags <= {alu_pos, alu_neg, alu_zero};
                end
                if (w_op == OP_STR) r_rf[w_idx] <= r_acc;
                if (w_op != OP_HLT) r_pc <= w_take ? CNTR_WIDTH'(w_opnd) : r_pc + CNTR_WIDTH'(1);
            end
        end
    end
endmodule

// File: tb/tb_exec_seq.sv
// tb_exec_seq: scoreboard bench for exec_seq with a behavioural ISA model,
// a stalling instruction memory and a combinational ALU model.
module tb_exec_seq;
    localparam int DW = 8, AW = 5, CW = 8, RB = 3;
    localparam int NOP = 0, LDI = 1, LDR = 2, ADDI = 3, SUBI = 4, ADDR = 5, SUBR = 6,
                   AND_ = 7, OR_ = 8, XOR_ = 9, SHL = 10, SHR = 11, ROL = 12, ROR = 13,
                   INC = 14, DEC = 15, NOT_ = 16, STR = 17, JMP = 18, JZ = 19, JLZ = 20,
                   JGZ = 21, HLT = 22;

    logic           clk = 0, rst_n = 0, start = 0, imem_valid = 0;
    logic           imem_req, halted, alu_zero, alu_neg, alu_pos;
    logic [CW-1:0]  imem_addr;
    logic [AW+DW-1:0] imem_data = '0;
    logic [AW-1:0]  alu_op;
    logic [DW-1:0]  alu_in1, alu_in2, alu_result, acc;
    logic [2:0]     flags;

    exec_seq #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNTR_WIDTH(CW), .REG_BIT_CNT(RB)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_data(imem_data), .alu_op(alu_op), .alu_in1(alu_in1),
        .alu_in2(alu_in2), .alu_result(alu_result), .alu_zero(alu_zero), .alu_neg(alu_neg),
        .alu_pos(alu_pos), .acc(acc), .flags(flags), .halted(halted));

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_f(int op, logic [7:0] a, logic [7:0] b);
        case (op)
            LDI, LDR:   return b;
            ADDI, ADDR: return a + b;
            SUBI, SUBR: return a - b;
            AND_:       return a & b;
            OR_:        return a | b;
            XOR_:       return a ^ b;
            SHL:        return a << 1;
            SHR:        return a >> 1;
            ROL:        return {a[6:0], a[7]};
            ROR:        return {a[0], a[7:1]};
            INC:        return a + 8'd1;
            DEC:        return a - 8'd1;
            NOT_:       return ~a;
            default:    return a;
        endcase
    endfunction

    assign alu_result = alu_f(int'(alu_op), alu_in1, alu_in2);
    assign alu_zero   = alu_result == 8'd0;
    assign alu_neg    = alu_result[7];
    assign alu_pos    = !alu_zero && !alu_result[7];

    typedef struct {logic [7:0] acc; logic [2:0] fl; int cyc;} fin_t;

    logic [12:0] mem [256];
    int          addr_q[$], stall_q[$], m_addrs[$];
    fin_t        fin_q[$];
    logic [7:0]  m_acc = 0, m_rf [8];
    logic [2:0]  m_fl = 0;
    int          checks = 0, errors = 0, m_cur = -1, cyc = 0;
    bit          in_run = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [12:0] enc(int op, logic [7:0] v);
        return {5'(op), v};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = enc(HLT, 0);
    endtask

    // ISA-level interpreter: records the fetch trace and updates the architectural state.
    task automatic model_exec(output bit ok);
        logic [7:0] pc = 0;
        m_addrs.delete();
        ok = 0;
        for (int s = 0; s < 100 && !ok; s++) begin
            int op;
            logic [7:0] v, r;
            m_addrs.push_back(int'(pc));
            op = int'(mem[pc][12:8]);
            v  = mem[pc][7:0];
            if (op <= NOT_) begin
                r = alu_f(op, m_acc, (op == LDI || op == ADDI || op == SUBI) ? v : m_rf[v[2:0]]);
                m_acc = r;
                m_fl = {r != 0 && !r[7], r[7], r == 0};
                pc++;
            end else if (op == STR) begin
                m_rf[v[2:0]] = m_acc;
                pc++;
            end else if (op == HLT) ok = 1;
            else if (op == JMP || (op == JZ && m_fl[0]) || (op == JLZ && m_fl[1]) || (op == JGZ && m_fl[2])) pc = v;
            else pc++;
        end
    endtask

    task automatic enqueue(input bit rnd, input int s_idx, input int s_len);
        int sum = 0, st;
        fin_t f;
        foreach (m_addrs[i]) begin
            st = rnd ? int'($urandom_range(0, 3)) : (i == s_idx ? s_len : 0);
            stall_q.push_back(st);
            addr_q.push_back(m_addrs[i]);
            sum += st;
        end
        f.acc = m_acc; f.fl = m_fl; f.cyc = 3 * m_addrs.size() + sum;
        fin_q.push_back(f);
    endtask

    task automatic launch(input bit rnd, input int s_idx, input int s_len);
        bit ok;
        model_exec(ok);
        enqueue(rnd, s_idx, s_len);
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        for (int t = 0; t < 3000 && !halted; t++) begin
            @(negedge clk);
            start = !halted && ($urandom % 4 == 0);
        end
        start = 0;
        if (!halted) chk("halt_timeout", 0, 1);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        #2;
        chk("rst_acc", acc, 0);
        chk("rst_flags", flags, 0);
        chk("rst_req", imem_req, 0);
        chk("rst_halted", halted, 0);
        addr_q.delete(); fin_q.delete(); stall_q.delete();
        in_run = 0; m_cur = -1; m_acc = 0; m_fl = 0;
        for (int i = 0; i < 8; i++) m_rf[i] = 0;
        @(negedge clk);
        rst_n = 1;
    endtask

    // Instruction memory: per-fetch stall from stall_q, junk valid/data outside FETCH.
    initial forever begin
        @(negedge clk);
        if (imem_req) begin
            if (m_cur < 0) m_cur = stall_q.size() > 0 ? stall_q.pop_front() : 0;
            if (m_cur > 0) begin
                imem_valid = 0; imem_data = 13'($urandom); m_cur--;
            end else begin
                imem_valid = 1; imem_data = mem[imem_addr]; m_cur = -1;
            end
        end else begin
            imem_valid = 1'($urandom % 2);
            imem_data  = 13'($urandom);
        end
    end

    // Monitor: fetch-address trace and end-of-program state against the scoreboard.
    initial forever begin
        fin_t f;
        @(negedge clk);
        #1;
        if (!rst_n) continue;
        if (imem_req && !in_run) begin in_run = 1; cyc = 0; end
        else if (in_run) cyc++;
        if (imem_req) begin
            if (addr_q.size() == 0) chk("fetch_unexpected", imem_addr, 32'hFFFF);
            else begin
                chk("fetch_addr", imem_addr, addr_q[0]);
                if (imem_valid) void'(addr_q.pop_front());
            end
        end
        if (in_run && halted) begin
            in_run = 0;
            if (fin_q.size() == 0) chk("halt_unexpected", 1, 0);
            else begin
                f = fin_q.pop_front();
                chk("final_acc", acc, f.acc);
                chk("final_flags", flags, f.fl);
                chk("cycles", cyc, f.cyc);
                chk("fetches_left", addr_q.size(), 0);
            end
        end
    end

    initial begin
        logic [7:0] s_acc, s_rf [8];
        logic [2:0] s_fl;
        bit ok;
        int hs;
        do_reset();
        repeat (3) begin
            @(negedge clk); #2;
            chk("idle_req", imem_req, 0);
        end
        clear_mem();
        mem[0] = enc(LDI, 5); mem[1] = enc(ADDI, 3); mem[2] = enc(HLT, 0);
        launch(0, 0, 0);
        chk("p1_acc", acc, 8); chk("p1_flags", flags, 3'b100); chk("p1_halted", halted, 1);
        launch(0, 1, 4);
        chk("stall_acc", acc, 8);
        clear_mem();
        mem[0] = enc(LDI, 1); mem[1] = enc(DEC, 0); mem[2] = enc(JZ, 5);
        launch(0, 0, 0);
        chk("jz_flags", flags, 3'b001);
        mem[0] = enc(LDI, 2);
        launch(0, 0, 0);
        chk("nojz_acc", acc, 1);
        clear_mem();
        mem[0] = enc(LDI, 8'h7F); mem[1] = enc(STR, 3); mem[2] = enc(LDI, 0);
        mem[3] = enc(LDR, 3); mem[4] = enc(HLT, 0);
        launch(0, 0, 0);
        chk("ldr_acc", acc, 8'h7F); chk("ldr_flags", flags, 3'b100);
        clear_mem();
        mem[0] = enc(JLZ, 4); mem[1] = enc(LDI, 8'h80); mem[2] = enc(JMP, 8'hFF);
        mem[255] = enc(NOP, 0); mem[4] = enc(HLT, 0);
        launch(0, 0, 0);
        chk("wrap_flags", flags, 3'b010);
        clear_mem();
        mem[0] = enc(LDI, 5); mem[1] = enc(ADDI, 3); mem[2] = enc(HLT, 0);
        model_exec(ok);
        enqueue(0, 0, 0);
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        hs = 0;
        for (int t = 0; t < 50 && hs < 2; t++) begin
            if (t > 0) @(negedge clk);
            #1;
            if (imem_req && imem_valid) hs++;
        end
        chk("pre_rst_hs", hs, 2);
        chk("pre_rst_acc", acc, 5);
        do_reset();
        launch(0, 0, 0);
        chk("post_rst_acc", acc, 8);
        for (int n = 0; n < 30; n++) begin
            s_acc = m_acc; s_fl = m_fl;
            for (int i = 0; i < 8; i++) s_rf[i] = m_rf[i];
            ok = 0;
            for (int tries = 0; tries < 50 && !ok; tries++) begin
                clear_mem();
                for (int a = 0; a < 16; a++) begin
                    int op;
                    op = int'($urandom_range(0, 24));
                    mem[a] = enc(op, (op >= JMP && op <= JGZ) ? 8'($urandom_range(0, 20)) : 8'($urandom));
                end
                model_exec(ok);
                m_acc = s_acc; m_fl = s_fl;
                for (int i = 0; i < 8; i++) m_rf[i] = s_rf[i];
            end
            if (ok) launch(1, 0, 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
